// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, ALU opcodes and sequencer states for alu_sequencer.
package alu_seq_pkg;
  localparam int DATA_W   = 8;
  localparam int OP_W     = 3;
  localparam int NUM_REGS = 4;
  localparam int REG_AW   = $clog2(NUM_REGS);
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOR = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_NOR;
  endfunction
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NUM_REGS x DATA_W register file, async clear, one write port,
// three combinational read ports (operand A, operand B, debug).
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  input  logic [REG_AW-1:0] raddr_dbg_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_dbg_o
);
  logic [DATA_W-1:0] mem_q [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_a_o   = mem_q[raddr_a_i];
  assign rdata_b_o   = mem_q[raddr_b_i];
  assign rdata_dbg_o = mem_q[raddr_dbg_i];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: serialises commands into an external combinational ALU,
// writes results back to a small register file and returns them on a response channel.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [REG_AW-1:0] cmd_dst,
  input  logic [REG_AW-1:0] cmd_src_a,
  input  logic [REG_AW-1:0] cmd_src_b,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              accept, illegal, we;

  assign accept  = cmd_valid && cmd_ready_q;
  assign illegal = op_illegal(alu_op_q);
  assign we      = (state_q == EXEC) && !illegal;

  alu_seq_regfile u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (we),
    .waddr_i     (dst_q),
    .wdata_i     (alu_result),
    .raddr_a_i   (cmd_src_a),
    .raddr_b_i   (cmd_src_b),
    .raddr_dbg_i (dbg_addr),
    .rdata_a_o   (rd_a),
    .rdata_b_o   (rd_b),
    .rdata_dbg_o (dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    dst_d       = dst_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = !accept;
        if (accept) begin
          dst_d    = cmd_dst;
          alu_a_d  = rd_a;
          alu_b_d  = cmd_imm_en ? cmd_imm : rd_b;
          alu_op_d = cmd_op;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // illegal opcodes report a zero result with the zero flag set
        rsp_valid_d = 1'b1;
        rsp_data_d  = illegal ? '0 : alu_result;
        rsp_zero_d  = illegal | alu_zero;
        rsp_err_d   = illegal;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      dst_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      dst_q       <= dst_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer with a behavioural ALU
// attached to its ALU ports.
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_dst = '0, cmd_src_a = '0, cmd_src_b = '0;
  logic       cmd_imm_en = 1'b0;
  logic [7:0] cmd_imm = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic       alu_zero;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_zero, rsp_err;
  logic [7:0] rsp_data;
  logic [1:0] dbg_addr = '0;
  logic [7:0] dbg_data;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_dst(cmd_dst),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External ALU; illegal opcodes yield a nonzero junk value the sequencer must mask.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~(alu_a | alu_b);
      default: alu_result = 8'hA5;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {7'd0, cmd_ready}, 8'h00);
    chk({tag, "_rsp_valid"}, {7'd0, rsp_valid}, 8'h00);
    chk({tag, "_rsp_data"}, rsp_data, 8'h00);
    chk({tag, "_rsp_zero"}, {7'd0, rsp_zero}, 8'h00);
    chk({tag, "_rsp_err"}, {7'd0, rsp_err}, 8'h00);
    chk({tag, "_alu_a"}, alu_a, 8'h00);
    chk({tag, "_alu_b"}, alu_b, 8'h00);
    chk({tag, "_alu_op"}, {5'd0, alu_opcode}, 8'h00);
    for (int i = 0; i < 4; i++) chk_dbg({tag, "_dbg"}, 2'(i), 8'h00);
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] a,
                       input logic [1:0] b, input logic ie, input logic [7:0] imm);
    cmd_op = op; cmd_dst = dst; cmd_src_a = a; cmd_src_b = b; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready_timeout"}, {7'd0, n < 20}, 8'h01);
  endtask

  // Full transaction with rsp_ready held high: accept, EXEC, response, handshake.
  task automatic run(input string tag, input logic [2:0] op, input logic [1:0] dst,
                     input logic [1:0] a, input logic [1:0] b, input logic ie, input logic [7:0] imm,
                     input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ed,
                     input logic ez, input logic ee);
    rsp_ready = 1'b1;
    drive(op, dst, a, b, ie, imm);
    wait_ready(tag);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, "_acc_cmd_ready"}, {7'd0, cmd_ready}, 8'h00);
    chk({tag, "_acc_rsp_valid"}, {7'd0, rsp_valid}, 8'h00);
    chk({tag, "_alu_a"}, alu_a, ea);
    chk({tag, "_alu_b"}, alu_b, eb);
    chk({tag, "_alu_op"}, {5'd0, alu_opcode}, {5'd0, op});
    @(posedge clk); #1;
    chk({tag, "_rsp_valid"}, {7'd0, rsp_valid}, 8'h01);
    chk({tag, "_rsp_data"}, rsp_data, ed);
    chk({tag, "_rsp_zero"}, {7'd0, rsp_zero}, {7'd0, ez});
    chk({tag, "_rsp_err"}, {7'd0, rsp_err}, {7'd0, ee});
    @(posedge clk); #1;
    chk({tag, "_done_rsp_valid"}, {7'd0, rsp_valid}, 8'h00);
    chk({tag, "_done_cmd_ready"}, {7'd0, cmd_ready}, 8'h01);
  endtask

  initial begin
    // bring-up: assert reset mid-cycle before any clock edge
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("reset");
    #5 rst_n = 1'b1;
    #1 chk("bringup_ready_before_edge", {7'd0, cmd_ready}, 8'h00);
    @(posedge clk); #1;
    chk("bringup_ready_after_edge", {7'd0, cmd_ready}, 8'h01);

    run("or_r0", 3'b011, 2'd0, 2'd1, 2'd0, 1'b1, 8'h08, 8'h00, 8'h08, 8'h08, 1'b0, 1'b0);
    run("or_r1", 3'b011, 2'd1, 2'd1, 2'd0, 1'b1, 8'h04, 8'h00, 8'h04, 8'h04, 1'b0, 1'b0);
    run("add_r2", 3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 8'hFF, 8'h08, 8'h04, 8'h0C, 1'b0, 1'b0);
    chk_dbg("dbg_r2_add", 2'd2, 8'h0C);
    run("sub_wrap", 3'b001, 2'd3, 2'd1, 2'd0, 1'b0, 8'h00, 8'h04, 8'h08, 8'hFC, 1'b0, 1'b0);
    chk_dbg("dbg_r3_wrap", 2'd3, 8'hFC);
    run("sub_zero", 3'b001, 2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 8'h08, 8'h08, 8'h00, 1'b1, 1'b0);
    chk_dbg("dbg_r3_zero", 2'd3, 8'h00);
    run("nor_imm", 3'b101, 2'd3, 2'd0, 2'd0, 1'b1, 8'hF7, 8'h08, 8'hF7, 8'h00, 1'b1, 1'b0);
    run("illegal", 3'b110, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h08, 8'h04, 8'h00, 1'b1, 1'b1);
    chk_dbg("dbg_r2_after_illegal", 2'd2, 8'h0C);
    run("illegal7", 3'b111, 2'd0, 2'd0, 2'd1, 1'b0, 8'h00, 8'h08, 8'h04, 8'h00, 1'b1, 1'b1);
    chk_dbg("dbg_r0_after_illegal7", 2'd0, 8'h08);
    run("self_add", 3'b000, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h04, 8'h04, 8'h08, 1'b0, 1'b0);
    chk_dbg("dbg_r1_self", 2'd1, 8'h08);

    // backpressure: XOR r0 = 0x08 ^ 0xFF, with a second command queued during the hold
    rsp_ready = 1'b0;
    drive(3'b100, 2'd0, 2'd0, 2'd0, 1'b1, 8'hFF);
    wait_ready("bp");
    @(posedge clk); #1;
    drive(3'b010, 2'd2, 2'd0, 2'd0, 1'b1, 8'h0F);
    @(posedge clk); #1;
    chk("bp_rsp_valid", {7'd0, rsp_valid}, 8'h01);
    chk("bp_rsp_data", rsp_data, 8'hF7);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {7'd0, rsp_valid}, 8'h01);
      chk("bp_hold_data", rsp_data, 8'hF7);
      chk("bp_hold_zero", {7'd0, rsp_zero}, 8'h00);
      chk("bp_hold_ready", {7'd0, cmd_ready}, 8'h00);
      chk("bp_hold_alu_op", {5'd0, alu_opcode}, 8'h04);
      chk("bp_hold_alu_a", alu_a, 8'h08);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {7'd0, rsp_valid}, 8'h00);
    chk("bp_release_ready", {7'd0, cmd_ready}, 8'h01);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_queued_accept", {7'd0, cmd_ready}, 8'h00);
    chk("bp_queued_alu_a", alu_a, 8'hF7);
    chk("bp_queued_alu_b", alu_b, 8'h0F);
    chk("bp_queued_alu_op", {5'd0, alu_opcode}, 8'h02);
    @(posedge clk); #1;
    chk("bp_queued_rsp_valid", {7'd0, rsp_valid}, 8'h01);
    chk("bp_queued_rsp_data", rsp_data, 8'h07);
    @(posedge clk); #1;
    chk("bp_queued_done", {7'd0, cmd_ready}, 8'h01);
    chk_dbg("dbg_r0_xor", 2'd0, 8'hF7);
    chk_dbg("dbg_r2_and", 2'd2, 8'h07);

    // reset while a response is stalled in RESP
    rsp_ready = 1'b0;
    drive(3'b011, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01);
    wait_ready("rr");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr_rsp_valid_pre", {7'd0, rsp_valid}, 8'h01);
    chk("rr_rsp_data_pre", rsp_data, 8'hF7);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero_outputs("rr_reset");
    #2 rst_n = 1'b1;
    #1 chk("rr_ready_before_edge", {7'd0, cmd_ready}, 8'h00);
    @(posedge clk); #1;
    chk("rr_ready_after_edge", {7'd0, cmd_ready}, 8'h01);
    run("rr_or_r0", 3'b011, 2'd0, 2'd1, 2'd0, 1'b1, 8'h08, 8'h00, 8'h08, 8'h08, 1'b0, 1'b0);
    chk_dbg("rr_dbg_r0", 2'd0, 8'h08);
    chk_dbg("rr_dbg_r3", 2'd3, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
